// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: state encodings,
// default counter width, load/count mode encodings and a width helper.
package counter_seq_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic MODO_LOAD  = 1'b1;
    localparam logic MODO_COUNT = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_COUNT = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Bits needed to hold the values 0..maxCount inclusive.
    function automatic int wdogWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_cycle_watchdog.sv
// Saturating cycle watchdog: counts enabled cycles since the last clear and
// flags expiry once MAX cycles have been seen.
module counter_seq_ctrl_cycle_watchdog
    import counter_seq_ctrl_pkg::*;
#(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int            CW      = wdogWidth(MAX);
    localparam logic [CW-1:0] MAX_VAL = CW'(MAX);

    logic [CW-1:0] r_count;

    // Count enabled cycles, holding at MAX so the expiry flag stays asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == MAX_VAL);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Initiator for an external loadable up-counter: loads a start value, verifies
// the load, counts to a terminal value and pulses done. A load-back mismatch or
// a watchdog expiry parks the controller in a sticky error state.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int WDOG_MAX = 2**WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] preset,
    input  logic [WIDTH-1:0] terminal,
    input  logic             hold,
    input  logic             abort,
    input  logic [WIDTH-1:0] Q,
    output logic             enb,
    output logic             modo,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             error
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_terminal;
    logic             w_match;
    logic             w_loadOk;
    logic             w_wdClear;
    logic             w_wdInc;
    logic             w_wdExpired;

    assign w_match   = (Q == r_terminal);
    assign w_loadOk  = (Q == r_preset);
    assign w_wdClear = (r_state == ST_CHECK);
    assign w_wdInc   = (r_state == ST_COUNT) && enb;

    counter_seq_ctrl_cycle_watchdog #(
        .MAX (WDOG_MAX)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_wdClear),
        .i_inc     (w_wdInc),
        .o_expired (w_wdExpired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture preset/terminal only when a start is accepted; abort suppresses it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_preset   <= '0;
            r_terminal <= '0;
        end else if ((r_state == ST_IDLE) && start && !abort) begin
            r_preset   <= preset;
            r_terminal <= terminal;
        end
    end

    // Next-state and Moore outputs; enb in COUNT also depends on hold and Q.
    always_comb begin
        w_next = r_state;
        enb    = 1'b0;
        modo   = MODO_COUNT;
        data   = '0;
        busy   = 1'b1;
        done   = 1'b0;
        error  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                enb    = 1'b1;
                modo   = MODO_LOAD;
                data   = r_preset;
                w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_next = w_loadOk ? ST_COUNT : ST_ERROR;
            end
            ST_COUNT: begin
                enb = !hold && !w_match && !w_wdExpired;
                if (w_match) begin
                    w_next = ST_DONE;
                end else if (w_wdExpired) begin
                    w_next = ST_ERROR;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_next = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: drives directed operations against a behavioural
// 4-bit loadable counter (with selectable fault modes). Expected completion and
// error events go into a scoreboard queue that a negedge monitor drains.
module tb_counter_seq_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] preset;
    logic [3:0] terminal;
    logic       hold;
    logic       abort;
    logic [3:0] Q;
    logic       enb;
    logic       modo;
    logic [3:0] data;
    logic       busy;
    logic       done;
    logic       error;

    // 0 = healthy counter, 1 = output stuck at 0, 2 = loads but never counts
    int faultMode;
    int cyc;
    int checkCount;
    int passCount;
    int monEnbCnt;
    logic prevErr;

    typedef struct {
        bit         isErr;
        int         cycle;
        int         enbCnt;
        logic [3:0] q;
    } exp_t;

    exp_t sbQ[$];

    counter_seq_ctrl #(
        .WIDTH    (4),
        .WDOG_MAX (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .preset   (preset),
        .terminal (terminal),
        .hold     (hold),
        .abort    (abort),
        .Q        (Q),
        .enb      (enb),
        .modo     (modo),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter; spec cycle number of the period after edge n is n+1.
    always @(posedge clk) cyc <= cyc + 1;

    // External loadable up-counter with fault injection.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= 4'd0;
        end else begin
            case (faultMode)
                1: Q <= 4'd0;
                2: if (enb && modo) Q <= data;
                default: if (enb) Q <= modo ? data : Q + 4'd1;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    // Monitor: count count-mode enables and score every done pulse / error rise.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (enb === 1'b1 && modo === 1'b0) monEnbCnt++;
            if (done === 1'b1 || (error === 1'b1 && prevErr !== 1'b1)) begin
                if (sbQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_event: done=%b error=%b, expected none (cycle %0d)", done, error, cyc + 1);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("evt_is_error", {31'd0, error}, {31'd0, e.isErr});
                    checkOutput("evt_cycle", cyc + 1, e.cycle);
                    checkOutput("evt_enb_cycles", monEnbCnt, e.enbCnt);
                    if (!e.isErr) checkOutput("evt_q_at_done", {28'd0, Q}, {28'd0, e.q});
                end
                monEnbCnt = 0;
            end
        end
        prevErr = error;
    end

    // Advance to 1ns after edge n.
    task automatic toEdge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] p, input logic [3:0] t, output int k);
        @(posedge clk);
        #1;
        preset    = p;
        terminal  = t;
        start     = 1'b1;
        monEnbCnt = 0;
        k         = cyc + 1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        preset   = ~p;
        terminal = ~t;
        checkOutput("load_enb", {31'd0, enb}, 32'd1);
        checkOutput("load_modo", {31'd0, modo}, 32'd1);
        checkOutput("load_data", {28'd0, data}, {28'd0, p});
        checkOutput("load_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sbQ.size() != 0 && n < 100);
        #1;
        if (sbQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain_timeout: %0d events pending, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic abortPulse();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    initial begin
        int k;
        checkCount = 0;
        passCount  = 0;
        monEnbCnt  = 0;
        faultMode  = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        preset     = 4'd0;
        terminal   = 4'd0;
        hold       = 1'b0;
        abort      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_enb", {31'd0, enb}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        reset_n = 1'b1;

        // Reset asserted mid-COUNT: outputs drop at once, no done afterwards.
        applyStimulus(4'd0, 4'd5, k);
        toEdge(k + 4);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_enb", {31'd0, enb}, 32'd0);
        checkOutput("midrst_modo", {31'd0, modo}, 32'd0);
        checkOutput("midrst_data", {28'd0, data}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        checkOutput("midrst_error", {31'd0, error}, 32'd0);
        toEdge(k + 6);
        reset_n = 1'b1;
        toEdge(k + 18);
        checkOutput("midrst_idle", {31'd0, busy}, 32'd0);

        // Plain count 0 -> 5: five enables, done in k+9.
        applyStimulus(4'd0, 4'd5, k);
        sbQ.push_back('{1'b0, k + 9, 5, 4'd5});
        waitDrain();

        // Wrap-around 14 -> 2: four enables, done in k+8.
        applyStimulus(4'd14, 4'd2, k);
        sbQ.push_back('{1'b0, k + 8, 4, 4'd2});
        waitDrain();

        // Equal preset and terminal: no counting, done in k+4.
        applyStimulus(4'd7, 4'd7, k);
        sbQ.push_back('{1'b0, k + 4, 0, 4'd7});
        waitDrain();

        // Hold for three COUNT cycles: Q frozen, done slips to k+10.
        applyStimulus(4'd0, 4'd3, k);
        sbQ.push_back('{1'b0, k + 10, 3, 4'd3});
        toEdge(k + 3);
        hold = 1'b1;
        toEdge(k + 5);
        checkOutput("hold_q_frozen_a", {28'd0, Q}, 32'd1);
        toEdge(k + 6);
        checkOutput("hold_q_frozen_b", {28'd0, Q}, 32'd1);
        hold = 1'b0;
        waitDrain();

        // Counter stuck at 0: load-back check fails, error from k+3, sticky.
        faultMode = 1;
        applyStimulus(4'd3, 4'd9, k);
        sbQ.push_back('{1'b1, k + 3, 0, 4'd0});
        waitDrain();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_sticky", {31'd0, error}, 32'd1);
        checkOutput("err_busy", {31'd0, busy}, 32'd1);
        checkOutput("err_enb", {31'd0, enb}, 32'd0);
        abortPulse();
        checkOutput("err_abort_error", {31'd0, error}, 32'd0);
        checkOutput("err_abort_busy", {31'd0, busy}, 32'd0);

        // Counter that never advances: watchdog trips after 16 enables, error in k+20.
        faultMode = 2;
        applyStimulus(4'd3, 4'd9, k);
        sbQ.push_back('{1'b1, k + 20, 16, 4'd0});
        waitDrain();
        checkOutput("wdog_enb", {31'd0, enb}, 32'd0);
        abortPulse();
        checkOutput("wdog_abort_error", {31'd0, error}, 32'd0);
        faultMode = 0;

        // Abort with start on the same edge during COUNT: back to IDLE, no capture.
        applyStimulus(4'd0, 4'd5, k);
        toEdge(k + 3);
        abort    = 1'b1;
        start    = 1'b1;
        preset   = 4'd9;
        terminal = 4'd9;
        toEdge(k + 4);
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_enb", {31'd0, enb}, 32'd0);
        checkOutput("abort_modo", {31'd0, modo}, 32'd0);
        toEdge(k + 5);
        checkOutput("abort_stay_idle", {31'd0, busy}, 32'd0);

        // Abort and start together in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        toEdge(k + 6);
        abort = 1'b0;
        start = 1'b0;
        checkOutput("idle_abort_start_busy", {31'd0, busy}, 32'd0);
        toEdge(k + 10);
        checkOutput("idle_abort_start_still", {31'd0, busy}, 32'd0);

        // Healthy operation still works after all the above (15 -> 0, d=1).
        applyStimulus(4'd15, 4'd0, k);
        sbQ.push_back('{1'b0, k + 5, 1, 4'd0});
        waitDrain();

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
